// File: rtl/rcv_drain_ctrl.sv
// Receive drain controller: sequences rcv_block's ready/ack handshake,
// buffers bytes with their error flags, and counts error events.
module rcv_drain_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       framing_error,
  input  logic                       overrun_error,
  output logic                       data_read,
  input  logic                       pop,
  output logic                       rd_valid,
  output logic [7:0]                 rd_data,
  output logic [1:0]                 rd_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  input  logic                       clr_stats,
  output logic [CNT_W-1:0]           ferr_cnt,
  output logic [CNT_W-1:0]           ovr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT
  } state_t;

  state_t         state;
  logic [9:0]     mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [9:0]     head;
  logic           push;
  logic           do_pop;

  logic           ferr_d1;
  logic           ferr_d2;
  logic           ovr_d1;
  logic           ovr_d2;
  logic           ferr_rise;
  logic           ovr_rise;

  assign full     = (count == CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign head     = mem[rptr];
  assign rd_data  = rd_valid ? head[9:2] : 8'h00;
  assign rd_err   = rd_valid ? head[1:0] : 2'b00;

  // A pop while full frees the slot this cycle's push lands in.
  assign push   = (state == S_IDLE) && data_ready && (!full || pop);
  assign do_pop = pop && rd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      data_read <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (push) begin
            state     <= S_ACK;
            data_read <= 1'b1;
          end
        end
        S_ACK: begin
          state     <= S_WAIT;
          data_read <= 1'b0;
        end
        S_WAIT: begin
          data_read <= 1'b0;
          if (!data_ready) state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          data_read <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {rx_data, framing_error, overrun_error};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Two-stage edge pipeline: a rise shows in the counter two cycles later.
  assign ferr_rise = ferr_d1 && !ferr_d2;
  assign ovr_rise  = ovr_d1 && !ovr_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_d1  <= 1'b0;
      ferr_d2  <= 1'b0;
      ovr_d1   <= 1'b0;
      ovr_d2   <= 1'b0;
      ferr_cnt <= '0;
      ovr_cnt  <= '0;
    end else begin
      ferr_d1 <= framing_error;
      ferr_d2 <= ferr_d1;
      ovr_d1  <= overrun_error;
      ovr_d2  <= ovr_d1;
      if (clr_stats) begin
        ferr_cnt <= '0;
        ovr_cnt  <= '0;
      end else begin
        if (ferr_rise && ferr_cnt != '1) ferr_cnt <= ferr_cnt + 1'b1;
        if (ovr_rise && ovr_cnt != '1) ovr_cnt <= ovr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Directed bench for rcv_drain_ctrl: handshake, FIFO order,
// error counters, reset mid-transaction and empty pops.
module tb_rcv_drain_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_ready;
  logic [7:0] rx_data;
  logic       framing_error;
  logic       overrun_error;
  logic       data_read;
  logic       pop;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [1:0] rd_err;
  logic [3:0] count;
  logic       full;
  logic       clr_stats;
  logic [7:0] ferr_cnt;
  logic [7:0] ovr_cnt;

  int n_chk = 0;
  int n_fail = 0;

  rcv_drain_ctrl #(.DEPTH(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_ready    (data_ready),
    .rx_data       (rx_data),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .data_read     (data_read),
    .pop           (pop),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .count         (count),
    .full          (full),
    .clr_stats     (clr_stats),
    .ferr_cnt      (ferr_cnt),
    .ovr_cnt       (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a byte, let it be acked, then release data_ready.
  task automatic send(input logic [7:0] d, input logic fe,
                      input logic oe);
    rx_data       = d;
    framing_error = fe;
    overrun_error = oe;
    data_ready    = 1'b1;
    step();
    chk("send_ack", data_read, 1);
    step();
    chk("send_ack_once", data_read, 0);
    data_ready    = 1'b0;
    framing_error = 1'b0;
    overrun_error = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; data_ready = 0; rx_data = 0; framing_error = 0;
    overrun_error = 0; pop = 0; clr_stats = 0;
    step(); step();
    chk("rst_data_read", data_read, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_ferr", ferr_cnt, 0);
    chk("rst_ovr", ovr_cnt, 0);
    rst = 1'b0;
    step();

    // 1: single byte
    rx_data = 8'h05; data_ready = 1'b1;
    chk("t1_pre_ack", data_read, 0);
    step();
    chk("t1_ack", data_read, 1);
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, 8'h05);
    chk("t1_err", rd_err, 0);
    chk("t1_count", count, 1);
    step();
    chk("t1_ack_drop", data_read, 0);
    step();
    chk("t1_no_repush", count, 1);
    data_ready = 1'b0;
    step();
    pop = 1'b1; step(); pop = 1'b0;
    chk("t1_pop_count", count, 0);
    chk("t1_pop_data", rd_data, 0);

    // 2: fill, blocked 9th byte, pop+push, drain
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("t2_full", full, 1);
    chk("t2_count8", count, 8);
    rx_data = 8'h18; data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_blocked_ack", data_read, 0);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("t2_popush_ack", data_read, 1);
    chk("t2_popush_count", count, 8);
    chk("t2_popush_head", rd_data, 8'h11);
    step();
    data_ready = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain", rd_data, 8'h11 + 8'(i));
      pop = 1'b1; step(); pop = 1'b0;
    end
    chk("t2_empty", count, 0);
    chk("t2_empty_valid", rd_valid, 0);

    // 3: framing error entry and counter
    send(8'hE3, 1'b1, 1'b0);
    step();
    chk("t3_err", rd_err, 2'b10);
    chk("t3_data", rd_data, 8'hE3);
    chk("t3_ferr", ferr_cnt, 1);
    pop = 1'b1; step(); pop = 1'b0;
    send(8'h32, 1'b0, 1'b0);
    chk("t3_good_err", rd_err, 2'b00);
    chk("t3_good_data", rd_data, 8'h32);
    pop = 1'b1; step(); pop = 1'b0;

    // 4: overrun saturation and clear priority
    for (int i = 0; i < 260; i++) begin
      overrun_error = 1'b1; step();
      overrun_error = 1'b0; step();
    end
    step(); step();
    chk("t4_sat", ovr_cnt, 255);
    chk("t4_ferr_kept", ferr_cnt, 1);
    overrun_error = 1'b1; clr_stats = 1'b1;
    step();
    chk("t4_clr", ovr_cnt, 0);
    step();
    clr_stats = 1'b0;
    chk("t4_clr_prio", ovr_cnt, 0);
    chk("t4_clr_ferr", ferr_cnt, 0);
    step(); step();
    chk("t4_clr_hold", ovr_cnt, 0);
    overrun_error = 1'b0; step();
    overrun_error = 1'b1; step();
    chk("t4_lat1", ovr_cnt, 0);
    step();
    chk("t4_lat2", ovr_cnt, 1);
    overrun_error = 1'b0;

    // 5: reset while in ACK
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("t5_count3", count, 3);
    rx_data = 8'hA3; data_ready = 1'b1;
    step();
    chk("t5_in_ack", data_read, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_ack", data_read, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_valid", rd_valid, 0);
    chk("t5_rst_ovr", ovr_cnt, 0);
    chk("t5_rst_ferr", ferr_cnt, 0);
    step();
    chk("t5_recapture_ack", data_read, 1);
    chk("t5_recapture_data", rd_data, 8'hA3);
    chk("t5_recapture_count", count, 1);
    step();
    data_ready = 1'b0;
    step();
    pop = 1'b1; step(); pop = 1'b0;

    // 6: pops on empty are ignored
    pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_count", count, 0);
      chk("t6_valid", rd_valid, 0);
    end
    pop = 1'b0;
    send(8'h33, 1'b0, 1'b0);
    chk("t6_head", rd_data, 8'h33);
    chk("t6_count1", count, 1);
    pop = 1'b1; step(); pop = 1'b0;
    chk("t6_drained", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rcv_drain_ctrl.md
# rcv_drain_ctrl

Receive-side controller that sequences the UART `rcv_block` and drains it into a small FIFO. It watches `data_ready`, captures `rx_data` together with its error flags, and issues the one-cycle `data_read` acknowledge. It also maintains saturating framing and overrun event counters. It sits between `rcv_block` and any byte consumer, so the consumer never handles `rcv_block`'s handshake directly.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of 2 and ≥ 2.
- `CNT_W`, default 8: width of each statistics counter.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_ready`  in  1  from `rcv_block`; a received byte is pending.
- `rx_data`  in  8  from `rcv_block`; the received byte.
- `framing_error`  in  1  from `rcv_block`, level.
- `overrun_error`  in  1  from `rcv_block`, level.
- `data_read`  out  1  to `rcv_block`; registered one-cycle acknowledge pulse.
- `pop`  in  1  consumer removes the head entry.
- `rd_valid`  out  1  FIFO not empty.
- `rd_data`  out  8  head byte (first-word fall-through); 0 when empty.
- `rd_err`  out  2  head entry flags {framing, overrun}; 0 when empty.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `full`  out  1  `count == DEPTH`.
- `clr_stats`  in  1  clears both counters.
- `ferr_cnt`  out  CNT_W  saturating count of `framing_error` rising edges.
- `ovr_cnt`  out  CNT_W  saturating count of `overrun_error` rising edges.

## Operation
- The FSM has three states: IDLE, ACK and WAIT.
- **IDLE, push condition.** `push = (state==IDLE) && data_ready && (!full || pop)`.
- **IDLE, on push.**
  - The block writes {`rx_data`, `framing_error`, `overrun_error`} at the write pointer.
  - It then moves to ACK.
- **IDLE, no push.** If `data_ready` is high but `full` is set and there is no `pop`, the block stays in IDLE and `data_read` stays 0. `rcv_block` is left to flag overrun.
- **ACK.** `data_read` is 1 for this cycle only, then the FSM moves to WAIT.
- **WAIT.** `data_read` is 0. The FSM stays in WAIT while `data_ready` is 1 and returns to IDLE once `data_ready` is 0. This prevents a single byte being pushed twice.
- **Pop.** `pop` with `rd_valid` set advances the read pointer. `pop` while empty is ignored.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- **Count update.**
  - `count` increases by `push` and decreases by valid `pop`.
  - A push and a pop in the same cycle leave `count` unchanged.
  - A pop while full frees the slot that the same cycle's push uses.
- **Edge detection.** Registered copies of `framing_error` and `overrun_error` (reset to 0) are used for edge detection. A rising edge increments the matching counter, which holds at 2^CNT_W−1.
- **Clear.** `clr_stats` zeroes both counters and takes priority over a same-cycle increment.
- **Reset.**
  - Applies to every state, including mid-transaction in ACK or WAIT.
  - It returns the FSM to IDLE, zeroes the pointers, `count`, both counters and the edge registers, and empties the FIFO.
  - A byte still pending in `rcv_block` after reset is captured again as a new push.

## Timing
- **Reset values.** `data_read`=0, `rd_valid`=0, `rd_data`=0, `rd_err`=0, `count`=0, `full`=0, `ferr_cnt`=0, `ovr_cnt`=0, state IDLE.
- **Push sequence.** With `data_ready` first sampled high in IDLE at cycle N:
  - The entry is written at the end of cycle N.
  - `rd_valid`, `count` and `rd_data` update in cycle N+1.
  - `data_read`=1 in cycle N+1 only.
  - The FSM is in WAIT from cycle N+2.
- **Back-to-back bytes.** The minimum spacing between pushes is 3 cycles; a UART byte takes ≥ 90 cycles at a 10-cycle bit period.
- **Read side.** `pop` sampled in cycle M exposes the next head in cycle M+1.
- **Counters.** A rising edge of an error input in cycle K is reflected in `ferr_cnt`/`ovr_cnt` at cycle K+2: one cycle for the edge register and one for the counter.
- **Outputs.** `full`, `rd_valid`, `rd_data` and `rd_err` are combinational from registered state only, not from inputs.

## Test plan
1. **Single byte.** Reset, then send byte 0x05 at a 100 ns bit period (10 ns clock). Required: exactly one `data_read` pulse, one cycle after `data_ready` rises; then `rd_valid`=1, `rd_data`=0x05, `rd_err`=0, `count`=1. A subsequent `pop` gives `count`=0 and `rd_data`=0.
2. **Fill and drain order.**
   - Push 0x10–0x17 with no pop. Required: `full`=1, `count`=8.
   - Hold a 9th byte 0x18 pending. Required: `data_read` stays 0.
   - Pop once in IDLE. Required: same-cycle push, `count` stays 8.
   - Drain the FIFO. Required: bytes read out in order 0x11–0x18, and the pointers wrap correctly.
3. **Framing error.** Send 0xE3 with stop bit 0. Required: head `rd_err`=2'b10 and `ferr_cnt`=1. The next good byte 0x32 gives `rd_err`=2'b00.
4. **Counter saturation and clear.** Apply 260 `overrun_error` pulses with `CNT_W`=8. Required: `ovr_cnt`=255. Then assert `clr_stats` in the same cycle as a rising edge. Required: `ovr_cnt`=0.
5. **Reset mid-transaction.** Hold 3 entries and assert `rst` while in ACK. Required: the next cycle shows `data_read`=0, `count`=0, `rd_valid`=0, state IDLE, and both counters 0.
6. **Pop on empty.** `pop`=1 for 5 cycles with the FIFO empty. Required: `count` stays 0, `rd_valid`=0, pointers unchanged. The next pushed byte 0x33 appears as the head.
